alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Multi-cycle controller around the 16-bit ripple add/sub datapath (mode 0 = add, mode 1 = subtract via B inversion and carry-in).
- Accepts one opcode-driven operation at a time and sequences it:
  - ADD/SUB complete in a single pass.
  - Unsigned MUL (shift-add) and DIV (restoring) iterate the add/sub unit WIDTH times.
- Produces a 2*WIDTH result, a carry flag and a 2-bit error code. Sits between the opcode/operand source and the result consumer.

Parameters:
- WIDTH, 16, operand width; result width is 2*WIDTH; MUL/DIV iteration count is WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- start  input  1  request; sampled only while busy=0
- opcode  input  4  0001 ADD, 0010 SUB, 0011 MUL, 0100 DIV; all others invalid
- dataA  input  WIDTH  operand A (dividend for DIV)
- dataB  input  WIDTH  operand B (divisor for DIV)
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; result/carry/err valid from this cycle on
- result  output  2*WIDTH  ADD/SUB: {0, sum}; MUL: product; DIV: {remainder, quotient}
- carry  output  1  ADD/SUB adder carry-out (c16); 0 for other opcodes
- err  output  2  00 ok, 01 signed overflow (ADD/SUB), 10 divide by zero, 11 invalid opcode

Behaviour:
- Reset: clk edge with rst_n=0 forces IDLE and clears busy, done, result, carry, err and all internal registers to 0. Applies mid-operation too: the operation is aborted and no done pulse follows.
- FSM states: IDLE, EXEC, ITER, FIN.
- IDLE: on the edge where start=1, latch opcode/dataA/dataB, set busy=1, go to EXEC. This edge is E0.
- EXEC (edge E1):
  - ADD/SUB: compute through the add/sub unit (SUB uses mode=1).
    - result = {WIDTH'b0, sum}; carry = c16.
    - err = 01 if c16^c15, else 00.
    - Go to FIN.
  - MUL: clear accumulator, load multiplier; go to ITER.
  - DIV: if dataB=0, result = 32'h0000_FFFF, carry=0, err=10, go to FIN. Otherwise clear the partial remainder and go to ITER.
  - Invalid opcode: result=0, carry=0, err=11, go to FIN.
- ITER: WIDTH edges E2..E(WIDTH+1), one add (MUL) or trial subtract (DIV) per edge. A 5-bit counter counts 0..WIDTH-1; on the last iteration write result, carry=0, err=00, go to FIN.
  - MUL: if the current multiplier LSB=1, add the multiplicand into the upper half; shift the {acc, multiplier} pair right 1, capturing the adder carry into the MSB.
  - DIV: shift {rem, quot} left 1; subtract the divisor from rem. If there is no borrow (c16=1), keep the difference and set the quot LSB to 1. Otherwise restore rem and set the quot LSB to 0.
- FIN: done=1 and busy=0 for exactly this cycle; return to IDLE. A start seen in FIN is ignored; the next start is accepted in IDLE.
- Latency from E0 to the done cycle:
  - ADD/SUB, div-by-zero, invalid: done visible after E2 (2 cycles).
  - MUL/DIV: done visible after E(WIDTH+2), i.e. 18 cycles at WIDTH=16.
- start while busy=1 is ignored; operand/opcode changes after E0 have no effect.
- result/carry/err hold their values until the next completed operation overwrites them. They are unchanged while busy.
- Arithmetic width rules:
  - All MUL/DIV arithmetic is unsigned, with a WIDTH+1-bit internal carry.
  - ADD/SUB overflow is two's-complement signed.
  - SUB carry = 1 means no borrow.

Test Plan:
- Reset: hold rst_n=0 for 2 edges -> busy=0, done=0, result=0, carry=0, err=00.
- ADD 0x0004+0x0002 -> result=0x00000006, carry=0, err=00, done 2 cycles after start.
- SUB 0x7FFF-0xFFFF -> result=0x00008000, carry=0, err=01. SUB 0x0005-0x0003 -> 0x00000002, carry=1, err=00.
- MUL 0xFFFF*0xFFFF -> result=0xFFFE0001, err=00, done exactly 18 cycles after start. Pulse start again mid-operation -> ignored, no extra done.
- DIV 100/7 -> result=0x0002000E (rem 2, quot 14), err=00. DIV 5/0 -> result=0x0000FFFF, err=10, done after 2 cycles.
- opcode 1111 -> err=11, result=0. Assert rst_n=0 at iteration 8 of a MUL -> outputs 0, IDLE next cycle, no done. A fresh ADD afterwards completes normally.

Source files
------------

// File: rtl/alu_sequencer.sv
// Multi-cycle ADD/SUB/MUL/DIV sequencer built around one shared WIDTH-bit add/sub unit.
// MUL is shift-add and DIV is restoring division, each taking WIDTH passes through the adder.
module alu_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [3:0]           opcode,
    input  logic [WIDTH-1:0]     dataA,
    input  logic [WIDTH-1:0]     dataB,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 carry,
    output logic [1:0]           err
);
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam logic [3:0] OP_DIV = 4'b0100;

    typedef enum logic [1:0] {IDLE, EXEC, ITER, FIN} state_t;

    state_t             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   acc_q, acc_d;   // MUL accumulator / DIV partial remainder
    logic [WIDTH-1:0]   lo_q, lo_d;     // MUL multiplier-product low half / DIV quotient
    logic [4:0]         cnt_q, cnt_d;
    logic [2*WIDTH-1:0] res_q, res_d;
    logic               rc_q, rc_d;
    logic [1:0]         re_q, re_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               carry_q, carry_d, busy_q, busy_d, done_q, done_d;
    logic [1:0]         err_q, err_d;

    // Shared add/sub unit: mode 1 subtracts by inverting y and injecting carry-in.
    logic [WIDTH-1:0] add_x, add_y, add_yi, add_sum, rem_sh;
    logic             add_mode, add_c16, add_c15, div_ok;
    logic [WIDTH:0]   add_full;

    assign add_yi   = add_y ^ {WIDTH{add_mode}};
    assign add_full = {1'b0, add_x} + {1'b0, add_yi} + {{WIDTH{1'b0}}, add_mode};
    assign add_sum  = add_full[WIDTH-1:0];
    assign add_c16  = add_full[WIDTH];
    assign add_c15  = add_x[WIDTH-1] ^ add_yi[WIDTH-1] ^ add_sum[WIDTH-1];

    // The shifted remainder is WIDTH+1 bits wide; its top bit guarantees the subtract succeeds.
    assign rem_sh = {acc_q[WIDTH-2:0], lo_q[WIDTH-1]};
    assign div_ok = add_c16 | acc_q[WIDTH-1];

    always_comb begin
        add_x    = a_q;
        add_y    = b_q;
        add_mode = (op_q == OP_SUB);
        if (state_q == ITER) begin
            if (op_q == OP_MUL) begin
                add_x    = acc_q;
                add_y    = lo_q[0] ? b_q : '0;
                add_mode = 1'b0;
            end else begin
                add_x    = rem_sh;
                add_y    = b_q;
                add_mode = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        rc_d     = rc_q;
        re_d     = re_q;
        result_d = result_q;
        carry_d  = carry_q;
        err_d    = err_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = opcode;
                    a_d     = dataA;
                    b_d     = dataB;
                    busy_d  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                acc_d   = '0;
                lo_d    = a_q;
                cnt_d   = '0;
                state_d = FIN;
                rc_d    = 1'b0;
                case (op_q)
                    OP_ADD, OP_SUB: begin
                        res_d = {{WIDTH{1'b0}}, add_sum};
                        rc_d  = add_c16;
                        re_d  = {1'b0, add_c16 ^ add_c15};
                    end
                    OP_MUL: state_d = ITER;
                    OP_DIV: begin
                        if (b_q == '0) begin
                            res_d = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                            re_d  = 2'b10;
                        end else begin
                            state_d = ITER;
                        end
                    end
                    default: begin
                        res_d = '0;
                        re_d  = 2'b11;
                    end
                endcase
            end
            ITER: begin
                if (op_q == OP_MUL) begin
                    acc_d = add_full[WIDTH:1];
                    lo_d  = {add_full[0], lo_q[WIDTH-1:1]};
                end else begin
                    acc_d = div_ok ? add_sum : rem_sh;
                    lo_d  = {lo_q[WIDTH-2:0], div_ok};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(WIDTH-1)) begin
                    res_d   = {acc_d, lo_d};
                    rc_d    = 1'b0;
                    re_d    = 2'b00;
                    state_d = FIN;
                end
            end
            FIN: begin
                result_d = res_q;
                carry_d  = rc_q;
                err_d    = re_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            rc_q     <= 1'b0;
            re_q     <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            err_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            rc_q     <= rc_d;
            re_q     <= re_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign carry  = carry_q;
    assign err    = err_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed and random checks of alu_sequencer against an arithmetic reference model.
module tb_alu_sequencer;
    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [3:0]  opcode;
    logic [15:0] dataA, dataB;
    logic        busy, done, carry;
    logic [31:0] result;
    logic [1:0]  err;
    int          checks = 0;
    int          errors = 0;

    alu_sequencer #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
        .dataA(dataA), .dataB(dataB), .busy(busy), .done(done),
        .result(result), .carry(carry), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operation's definition.
    task automatic model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         output logic [31:0] r, output logic c, output logic [1:0] e,
                         output int lat);
        int sd;
        r = 0; c = 0; e = 0; lat = 2;
        case (op)
            4'd1: begin
                r  = (32'(a) + 32'(b)) & 32'hFFFF;
                c  = (32'(a) + 32'(b)) > 32'hFFFF;
                sd = int'($signed(a)) + int'($signed(b));
                e  = (sd > 32767 || sd < -32768) ? 2'b01 : 2'b00;
            end
            4'd2: begin
                r  = (32'(a) - 32'(b)) & 32'hFFFF;
                c  = (a >= b);
                sd = int'($signed(a)) - int'($signed(b));
                e  = (sd > 32767 || sd < -32768) ? 2'b01 : 2'b00;
            end
            4'd3: begin
                r = 32'(a) * 32'(b);
                lat = 18;
            end
            4'd4: begin
                if (b == 0) begin
                    r = 32'h0000FFFF;
                    e = 2'b10;
                end else begin
                    r = {16'(a % b), 16'(a / b)};
                    lat = 18;
                end
            end
            default: e = 2'b11;
        endcase
    endtask

    task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input bit pulse);
        logic [31:0] er;
        logic        ec;
        logic [1:0]  ee;
        int          elat;
        int          n;
        model(op, a, b, er, ec, ee, elat);
        @(negedge clk);
        start = 1'b1; opcode = op; dataA = a; dataB = b;
        @(posedge clk); #1;
        check("busy_after_start", 64'(busy), 64'd1);
        start = 1'b0;
        opcode = 4'($urandom); dataA = 16'($urandom); dataB = 16'($urandom);
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (pulse && n == 5) begin
                start = 1'b1; opcode = 4'd1;
            end else begin
                start = 1'b0;
            end
        end
        check("latency", 64'(n), 64'(elat));
        check("result", 64'(result), 64'(er));
        check("carry", 64'(carry), 64'(ec));
        check("err", 64'(err), 64'(ee));
        check("busy_at_done", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check("done_one_cycle", 64'(done), 64'd0);
        check("result_hold", 64'(result), 64'(er));
        $display("op=%0d a=%04h b=%04h result=%08h carry=%0d err=%0d lat=%0d",
                 op, a, b, result, carry, err, n);
    endtask

    initial begin
        logic [3:0]  rop;
        logic [15:0] ra, rb;
        int          seen;
        rst_n = 1'b0; start = 1'b0; opcode = '0; dataA = '0; dataB = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_carry", 64'(carry), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        @(negedge clk); rst_n = 1'b1;

        run_op(4'd1, 16'h0004, 16'h0002, 1'b0);
        run_op(4'd2, 16'h7FFF, 16'hFFFF, 1'b0);
        run_op(4'd2, 16'h0005, 16'h0003, 1'b0);
        run_op(4'd3, 16'hFFFF, 16'hFFFF, 1'b1);
        run_op(4'd4, 16'd100, 16'd7, 1'b0);
        run_op(4'd4, 16'd5, 16'd0, 1'b0);
        run_op(4'hF, 16'h1234, 16'h5678, 1'b0);
        run_op(4'd1, 16'h7FFF, 16'h0001, 1'b0);
        run_op(4'd4, 16'hFFFF, 16'h0001, 1'b0);
        run_op(4'd4, 16'hFFFE, 16'hFFFF, 1'b0);

        // Abort a MUL with reset partway through its iterations.
        @(negedge clk);
        start = 1'b1; opcode = 4'd3; dataA = 16'h1234; dataB = 16'h5678;
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_result", 64'(result), 64'd0);
        check("abort_carry", 64'(carry), 64'd0);
        check("abort_err", 64'(err), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("abort_no_done", 64'(seen), 64'd0);
        $display("abort mid-MUL: done pulses after reset=%0d", seen);
        run_op(4'd1, 16'h1111, 16'h2222, 1'b0);

        repeat (30) begin
            case ($urandom_range(0, 5))
                0: rop = 4'd1;
                1: rop = 4'd2;
                2: rop = 4'd3;
                3, 4: rop = 4'd4;
                default: rop = 4'($urandom_range(5, 15));
            endcase
            ra = 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            run_op(rop, ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
